if_fetch_unit: RTL and testbench

//   Instruction-fetch stage placed directly downstream of the PC register.

---
 rtl/if_fetch_unit_if.sv | 35 +++
 rtl/if_fetch_unit.sv | 135 +++++++++++++
 tb/tb_if_fetch_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: bundles the fetch stage's PC-register, instruction-memory
// and decode-side signals.
//   pc_i / flush_i / fetch_stall_o       : PC register side
//   imem_req_o / imem_addr_o / imem_gnt_i
//   imem_rvalid_i / imem_rdata_i         : instruction memory side
//   id_valid_o / id_ready_i / id_pc_o
//   id_inst_o                            : decode side
// modport master is the fetch unit; modport slave is its surroundings.
interface if_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] pc_i;
    logic              flush_i;
    logic              fetch_stall_o;
    logic              imem_req_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic              imem_gnt_i;
    logic              imem_rvalid_i;
    logic [DATA_W-1:0] imem_rdata_i;
    logic              id_valid_o;
    logic              id_ready_i;
    logic [ADDR_W-1:0] id_pc_o;
    logic [DATA_W-1:0] id_inst_o;

    modport master (
        input  pc_i, flush_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i,
        output fetch_stall_o, imem_req_o, imem_addr_o, id_valid_o, id_pc_o, id_inst_o
    );

    modport slave (
        output pc_i, flush_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i,
        input  fetch_stall_o, imem_req_o, imem_addr_o, id_valid_o, id_pc_o, id_inst_o
    );
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage after the PC register.
// Issues each accepted PC to instruction memory, remembers it in a tag queue,
// pairs returned instructions with their PC in a FIFO towards decode, stalls
// the PC register when out of credit or not granted, and discards wrong-path
// responses after a flush.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : if_fetch_unit_if.master (PC, imem and decode handshakes)
module if_fetch_unit #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    if_fetch_unit_if.master bus
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    cnt_t inflight_q, inflight_d;
    cnt_t drop_q, drop_d;
    cnt_t fifo_cnt_q, fifo_cnt_d;
    ptr_t fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    ptr_t tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

    logic [ADDR_W-1:0] tag_q      [FIFO_DEPTH];
    logic [ADDR_W-1:0] tag_d      [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc_q  [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc_d  [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_inst_q[FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_inst_d[FIFO_DEPTH];

    logic [CW:0] occupancy;
    logic        credit, accept, resp, resp_drop, push, pop;

    always_comb begin
        // Credit counts both outstanding requests and buffered instructions,
        // so a response always finds a free FIFO slot.
        occupancy = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
        credit    = occupancy < (CW + 1)'(FIFO_DEPTH);

        bus.imem_req_o    = credit & ~bus.flush_i & ~rst;
        bus.imem_addr_o   = bus.pc_i;
        accept            = bus.imem_req_o & bus.imem_gnt_i;
        bus.fetch_stall_o = ~bus.flush_i & ~accept;

        // A stray rvalid with nothing outstanding is ignored.
        resp      = bus.imem_rvalid_i & (inflight_q != '0);
        resp_drop = resp & (bus.flush_i | (drop_q != '0));
        push      = resp & ~resp_drop;

        bus.id_valid_o = fifo_cnt_q != '0;
        bus.id_pc_o    = fifo_pc_q[fifo_rd_q];
        bus.id_inst_o  = fifo_inst_q[fifo_rd_q];
        pop            = bus.id_valid_o & bus.id_ready_i;

        inflight_d = inflight_q + cnt_t'(accept) - cnt_t'(resp);

        // On flush every still-outstanding request becomes a drop; earlier
        // pending drops are already part of inflight_q.
        drop_d = drop_q;
        if (bus.flush_i) begin
            drop_d = inflight_d;
        end else if (resp_drop) begin
            drop_d = drop_q - cnt_t'(1);
        end

        tag_d    = tag_q;
        tag_wr_d = tag_wr_q;
        tag_rd_d = tag_rd_q;
        if (accept) begin
            tag_d[tag_wr_q] = bus.pc_i;
            tag_wr_d        = tag_wr_q + ptr_t'(1);
        end
        if (resp) begin
            tag_rd_d = tag_rd_q + ptr_t'(1);
        end

        fifo_pc_d   = fifo_pc_q;
        fifo_inst_d = fifo_inst_q;
        fifo_wr_d   = fifo_wr_q;
        fifo_rd_d   = fifo_rd_q;
        fifo_cnt_d  = fifo_cnt_q;
        if (bus.flush_i) begin
            fifo_rd_d  = fifo_wr_q;
            fifo_cnt_d = '0;
        end else begin
            if (push) begin
                fifo_pc_d[fifo_wr_q]   = tag_q[tag_rd_q];
                fifo_inst_d[fifo_wr_q] = bus.imem_rdata_i;
                fifo_wr_d              = fifo_wr_q + ptr_t'(1);
            end
            if (pop) begin
                fifo_rd_d = fifo_rd_q + ptr_t'(1);
            end
            fifo_cnt_d = fifo_cnt_q + cnt_t'(push) - cnt_t'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= '0;
            drop_q     <= '0;
            fifo_cnt_q <= '0;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
        end else begin
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            fifo_cnt_q <= fifo_cnt_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
        end
    end

    // Storage needs no reset: entries are only read once the pointers say valid.
    always_ff @(posedge clk) begin
        tag_q       <= tag_d;
        fifo_pc_q   <= fifo_pc_d;
        fifo_inst_q <= fifo_inst_d;
    end

`ifndef SYNTHESIS
    rvalid_needs_inflight: assert property (
        @(posedge clk) disable iff (rst) bus.imem_rvalid_i |-> (inflight_q != '0)
    );
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    if_fetch_unit #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        rst, flush;
        logic [31:0] pc;
        logic        gnt, rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        req, stall, valid;
        logic [31:0] ipc, iinst;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic f, input logic [31:0] pc, input logic g,
                       input logic v, input logic [31:0] rd, input logic rdy,
                       input logic req, input logic stall, input logic valid,
                       input logic [31:0] ipc, input logic [31:0] iinst);
        vec_t t;
        t.rst = r; t.flush = f; t.pc = pc; t.gnt = g; t.rv = v; t.rdata = rd; t.rdy = rdy;
        t.req = req; t.stall = stall; t.valid = valid; t.ipc = ipc; t.iinst = iinst;
        vq.push_back(t);
    endtask

    task automatic drive(input logic f, input logic [31:0] pc, input logic g,
                         input logic v, input logic [31:0] rd, input logic rdy);
        bus.flush_i       = f;
        bus.pc_i          = pc;
        bus.imem_gnt_i    = g;
        bus.imem_rvalid_i = v;
        bus.imem_rdata_i  = rd;
        bus.id_ready_i    = rdy;
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);

        //   rst flush pc        gnt rv rdata         rdy  req stall valid id_pc     id_inst
        add(1, 0, 32'h000, 0, 0, 32'h0,        1,   0, 1, 0, 32'h0,   32'h0);        // in reset
        add(0, 0, 32'h000, 1, 0, 32'h0,        1,   1, 0, 0, 32'h0,   32'h0);        // grant pc 0
        add(0, 0, 32'h004, 1, 1, 32'hA0,       1,   1, 0, 0, 32'h0,   32'h0);        // grant 4, resp 0
        add(0, 0, 32'h008, 1, 1, 32'hA4,       1,   0, 1, 1, 32'h0,   32'hA0);       // credit exhausted
        add(0, 0, 32'h008, 1, 0, 32'h0,        1,   1, 0, 1, 32'h4,   32'hA4);       // grant 8
        add(0, 0, 32'h00C, 1, 1, 32'hA8,       1,   1, 0, 0, 32'h0,   32'h0);        // grant C, resp 8
        add(0, 0, 32'h010, 1, 1, 32'hAC,       0,   0, 1, 1, 32'h8,   32'hA8);       // backpressure starts
        add(0, 0, 32'h010, 1, 0, 32'h0,        0,   0, 1, 1, 32'h8,   32'hA8);
        add(0, 0, 32'h010, 1, 0, 32'h0,        0,   0, 1, 1, 32'h8,   32'hA8);
        add(0, 0, 32'h010, 1, 0, 32'h0,        0,   0, 1, 1, 32'h8,   32'hA8);
        add(0, 0, 32'h010, 1, 0, 32'h0,        1,   0, 1, 1, 32'h8,   32'hA8);       // full FIFO drains
        add(0, 0, 32'h010, 1, 0, 32'h0,        1,   1, 0, 1, 32'hC,   32'hAC);       // grant 10
        add(0, 0, 32'h014, 1, 0, 32'h0,        1,   1, 0, 0, 32'h0,   32'h0);        // grant 14, 2 in flight
        add(0, 1, 32'h014, 1, 0, 32'h0,        1,   0, 0, 0, 32'h0,   32'h0);        // flush
        add(0, 0, 32'h100, 1, 1, 32'hDEAD0001, 1,   0, 1, 0, 32'h0,   32'h0);        // drop 1
        add(0, 0, 32'h100, 1, 1, 32'hDEAD0002, 1,   1, 0, 0, 32'h0,   32'h0);        // drop 2, grant 100
        add(0, 0, 32'h104, 0, 1, 32'hB100,     1,   1, 1, 0, 32'h0,   32'h0);        // resp 100
        add(0, 0, 32'h104, 0, 0, 32'h0,        0,   1, 1, 1, 32'h100, 32'hB100);     // memory stall
        add(0, 0, 32'h104, 0, 0, 32'h0,        0,   1, 1, 1, 32'h100, 32'hB100);
        add(0, 0, 32'h104, 0, 0, 32'h0,        0,   1, 1, 1, 32'h100, 32'hB100);
        add(0, 0, 32'h104, 1, 0, 32'h0,        1,   1, 0, 1, 32'h100, 32'hB100);     // grant 104
        add(0, 0, 32'h108, 1, 0, 32'h0,        1,   1, 0, 0, 32'h0,   32'h0);        // grant 108
        add(0, 1, 32'h108, 1, 1, 32'hDEAD0003, 1,   0, 0, 0, 32'h0,   32'h0);        // flush+gnt+rvalid
        add(0, 0, 32'h200, 1, 0, 32'h0,        1,   1, 0, 0, 32'h0,   32'h0);        // grant 200
        add(0, 0, 32'h204, 1, 1, 32'hDEAD0004, 1,   0, 1, 0, 32'h0,   32'h0);        // drop resp 108
        add(0, 0, 32'h204, 0, 1, 32'hB200,     1,   1, 1, 0, 32'h0,   32'h0);        // resp 200
        add(0, 0, 32'h204, 0, 0, 32'h0,        1,   1, 1, 1, 32'h200, 32'hB200);
        add(0, 0, 32'h204, 0, 0, 32'h0,        1,   1, 1, 0, 32'h0,   32'h0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst = vq[i].rst;
            drive(vq[i].flush, vq[i].pc, vq[i].gnt, vq[i].rv, vq[i].rdata, vq[i].rdy);
            #1;
            check($sformatf("row%0d req", i),   32'(bus.imem_req_o),    32'(vq[i].req));
            check($sformatf("row%0d stall", i), 32'(bus.fetch_stall_o), 32'(vq[i].stall));
            check($sformatf("row%0d addr", i),  bus.imem_addr_o,        vq[i].pc);
            check($sformatf("row%0d valid", i), 32'(bus.id_valid_o),    32'(vq[i].valid));
            if (vq[i].valid) begin
                check($sformatf("row%0d id_pc", i),   bus.id_pc_o,   vq[i].ipc);
                check($sformatf("row%0d id_inst", i), bus.id_inst_o, vq[i].iinst);
            end
        end

        // Asynchronous reset with an instruction buffered, then a clean restart.
        @(negedge clk);
        drive(1'b0, 32'h300, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h304, 1'b0, 1'b1, 32'hC300, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h304, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        check("pre_reset valid", 32'(bus.id_valid_o), 32'h1);
        check("pre_reset id_pc", bus.id_pc_o, 32'h300);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset valid", 32'(bus.id_valid_o), 32'h0);
        check("async_reset req",   32'(bus.imem_req_o),  32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 32'h304, 1'b1, 1'b0, 32'h0, 1'b1);
        #1;
        check("restart req",   32'(bus.imem_req_o),    32'h1);
        check("restart stall", 32'(bus.fetch_stall_o), 32'h0);
        @(negedge clk);
        drive(1'b0, 32'h308, 1'b0, 1'b1, 32'hC304, 1'b1);
        #1;
        check("restart latency valid", 32'(bus.id_valid_o), 32'h0);
        @(negedge clk);
        drive(1'b0, 32'h308, 1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        check("restart valid",   32'(bus.id_valid_o), 32'h1);
        check("restart id_pc",   bus.id_pc_o,         32'h304);
        check("restart id_inst", bus.id_inst_o,       32'hC304);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
